// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: command/FSM encodings, fixed tms navigation patterns and the TAP state model
package jtag_seq_pkg;
   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_IDLE  = 2'd1;
   localparam logic [1:0] OP_IR    = 2'd2;
   localparam logic [1:0] OP_DR    = 2'd3;

   localparam logic [2:0] RST_SEQ = 3'd0;
   localparam logic [2:0] IDLE    = 3'd1;
   localparam logic [2:0] NAV_IN  = 3'd2;
   localparam logic [2:0] SHIFT   = 3'd3;
   localparam logic [2:0] NAV_OUT = 3'd4;
   localparam logic [2:0] RUNIDLE = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   // tms patterns, LSB is the first bit clocked out
   localparam logic [2:0] TMS_DR_IN = 3'b001;
   localparam logic [3:0] TMS_IR_IN = 4'b0011;
   localparam logic [1:0] TMS_OUT   = 2'b01;
   localparam logic [5:0] TMS_RESET = 6'b011111;

   typedef enum logic [4:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR, UNKNOWN
   } tap_state_t;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TLR:     tap_next = tms ? TLR    : RTI;
         RTI:     tap_next = tms ? SEL_DR : RTI;
         SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
         CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
         SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
         EX1_DR:  tap_next = tms ? UPD_DR : PAU_DR;
         PAU_DR:  tap_next = tms ? EX2_DR : PAU_DR;
         EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
         UPD_DR:  tap_next = tms ? SEL_DR : RTI;
         SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
         CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
         SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
         EX1_IR:  tap_next = tms ? UPD_IR : PAU_IR;
         PAU_IR:  tap_next = tms ? EX2_IR : PAU_IR;
         EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
         UPD_IR:  tap_next = tms ? SEL_DR : RTI;
         default: tap_next = UNKNOWN;
      endcase
   endfunction
endpackage

// File: rtl/jtag_tap_sequencer_tck_gen.sv
// jtag_tck_gen: tck divider; fall_stb marks the edge starting a bit, rise_stb the edge raising tck
module jtag_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tck,
   output logic fall_stb,
   output logic rise_stb
);
   localparam int CW = $clog2(2 * TCK_DIV);
   logic [CW-1:0] cnt, nxt;
   always_comb nxt = (cnt == CW'(2 * TCK_DIV - 1)) ? '0 : cnt + 1'b1;
   assign rise_stb = en && cnt == CW'(TCK_DIV - 1);
   assign fall_stb = en && cnt == CW'(2 * TCK_DIV - 1);
   always_ff @(posedge clk)
      if (rst || !en) begin
         cnt <= '0;
         tck <= 1'b0;
      end else begin
         cnt <= nxt;
         tck <= nxt >= CW'(TCK_DIV);
      end
endmodule

// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: host-side JTAG TAP master running IR/DR shift, idle and reset commands.
// Optional JTAG_SEQ_TRST_EN adds jtag_trst_n, pulsed before every tms reset sequence.
module jtag_tap_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int TCK_DIV = 2,
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               jtag_tck,
   output logic               jtag_tms,
   output logic               jtag_tdi,
   input  logic               jtag_tdo
`ifdef JTAG_SEQ_TRST_EN
   ,output logic              jtag_trst_n
`endif
);
   logic [2:0]         state;
   logic [1:0]         op_q;
   logic [LEN_W-1:0]   len_q, bit_cnt, eff_len, last_idx;
   logic [MAX_LEN-1:0] data_q, cap_q;
   logic [5:0]         nav_q, pat;
   logic               tck_en, fall_stb, rise_stb, hold, acc;
   tap_state_t         mirror;

`ifdef JTAG_SEQ_TRST_EN
   localparam int TW = $clog2(8 * TCK_DIV + 1);
   logic [TW-1:0] trst_cnt;
   assign hold = trst_cnt != '0;
   assign jtag_trst_n = !hold;
   always_ff @(posedge clk)
      if (rst || (acc && cmd_op == OP_RESET)) trst_cnt <= TW'(8 * TCK_DIV);
      else if (hold) trst_cnt <= trst_cnt - 1'b1;
`else
   assign hold = 1'b0;
`endif

   assign cmd_ready = state == IDLE && mirror == RTI;
   assign acc       = cmd_ready && cmd_valid;
   assign rsp_valid = state == DONE && op_q[1];
   assign tck_en    = !hold && state != IDLE && state != DONE;

   always_comb begin
      eff_len  = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : (cmd_op[1] && cmd_len == '0) ? LEN_W'(1) : cmd_len;
      pat      = cmd_op == OP_IR ? 6'(TMS_IR_IN) : cmd_op == OP_DR ? 6'(TMS_DR_IN) : cmd_op == OP_RESET ? TMS_RESET : 6'b0;
      last_idx = (state == SHIFT || state == RUNIDLE) ? len_q - 1'b1 :
                 state == RST_SEQ ? LEN_W'(5) : state == NAV_OUT ? LEN_W'(1) : op_q == OP_IR ? LEN_W'(3) : LEN_W'(2);
   end

   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
      .clk(clk), .rst(rst), .en(tck_en), .tck(jtag_tck), .fall_stb(fall_stb), .rise_stb(rise_stb)
   );

   always_ff @(posedge clk)
      if (rst) begin
         state    <= RST_SEQ;
         op_q     <= OP_RESET;
         len_q    <= '0;
         bit_cnt  <= '0;
         nav_q    <= TMS_RESET >> 1;
         jtag_tms <= 1'b1;
         jtag_tdi <= 1'b0;
         data_q   <= '0;
         cap_q    <= '0;
         rsp_data <= '0;
         busy     <= 1'b0;
         mirror   <= UNKNOWN;
      end else begin
         // five tms=1 bits force Test-Logic-Reset whatever the TAP was doing
         if (rise_stb) mirror <= (state == RST_SEQ && bit_cnt == LEN_W'(4)) ? TLR : tap_next(mirror, jtag_tms);
         if (rise_stb && state == SHIFT) cap_q <= {jtag_tdo, cap_q[MAX_LEN-1:1]};
         case (state)
            IDLE: if (acc) begin
               op_q     <= cmd_op;
               len_q    <= eff_len;
               data_q   <= cmd_data;
               cap_q    <= '0;
               bit_cnt  <= '0;
               busy     <= 1'b1;
               jtag_tdi <= 1'b0;
               jtag_tms <= pat[0];
               nav_q    <= pat >> 1;
               state    <= cmd_op == OP_RESET ? RST_SEQ : cmd_op == OP_IDLE ? (eff_len == '0 ? DONE : RUNIDLE) : NAV_IN;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: if (fall_stb) begin
               if (bit_cnt == last_idx) begin
                  bit_cnt  <= '0;
                  state    <= state == NAV_IN ? SHIFT : state == SHIFT ? NAV_OUT : DONE;
                  jtag_tms <= state == NAV_IN ? len_q == LEN_W'(1) : state == SHIFT;
                  jtag_tdi <= state == NAV_IN && data_q[0];
                  nav_q    <= 6'(TMS_OUT >> 1);
                  // captured bits sit at the top of cap_q; right-align them
                  if (state == SHIFT) rsp_data <= cap_q >> (MAX_LEN - int'(len_q));
               end else begin
                  bit_cnt  <= bit_cnt + 1'b1;
                  jtag_tms <= state == SHIFT ? bit_cnt + LEN_W'(2) == len_q : nav_q[0];
                  jtag_tdi <= state == SHIFT && data_q[1];
                  nav_q    <= nav_q >> 1;
                  if (state == SHIFT) data_q <= data_q >> 1;
               end
            end
         endcase
      end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: directed bench with a behavioural TAP (8-bit IR, IDCODE 32'h1234_5679, bypass)
module tb_jtag_tap_sequencer;
   localparam logic [1:0] OP_RESET = 2'd0, OP_IDLE = 2'd1, OP_IR = 2'd2, OP_DR = 2'd3;
   localparam logic [3:0] M_TLR = 0, M_RTI = 1, M_SDR = 2, M_CDR = 3, M_SHDR = 4, M_E1DR = 5, M_PDR = 6, M_E2DR = 7,
                          M_UDR = 8, M_SIR = 9, M_CIR = 10, M_SHIR = 11, M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid, cmd_ready, rsp_valid, busy;
   logic [1:0]  cmd_op;
   logic [6:0]  cmd_len;
   logic [63:0] cmd_data, rsp_data;
   logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo = 1'b0;

   int evals = 0, fails = 0;
   int tck_total = 0, rsp_total = 0, idle_viol = 0;
   logic tms_hist [0:1023];
   logic tdi_hist [0:1023];

   logic [3:0]  ts = M_PIR;
   logic [7:0]  ir = 8'h5A, ir_sr = 8'h00;
   logic [31:0] id_sr = 32'h0;
   logic        byp = 1'b0;

   jtag_tap_sequencer #(.TCK_DIV(2), .MAX_LEN(64), .LEN_W(7)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] m_next(input logic [3:0] s, input logic t);
      case (s)
         M_TLR:  return t ? M_TLR : M_RTI;
         M_RTI:  return t ? M_SDR : M_RTI;
         M_SDR:  return t ? M_SIR : M_CDR;
         M_CDR:  return t ? M_E1DR : M_SHDR;
         M_SHDR: return t ? M_E1DR : M_SHDR;
         M_E1DR: return t ? M_UDR : M_PDR;
         M_PDR:  return t ? M_E2DR : M_PDR;
         M_E2DR: return t ? M_UDR : M_SHDR;
         M_UDR:  return t ? M_SDR : M_RTI;
         M_SIR:  return t ? M_TLR : M_CIR;
         M_CIR:  return t ? M_E1IR : M_SHIR;
         M_SHIR: return t ? M_E1IR : M_SHIR;
         M_E1IR: return t ? M_UIR : M_PIR;
         M_PIR:  return t ? M_E2IR : M_PIR;
         M_E2IR: return t ? M_UIR : M_SHIR;
         default: return t ? M_SDR : M_RTI;
      endcase
   endfunction

   // TAP model: state and registers advance on tck rise, tdo changes on tck fall
   always @(posedge jtag_tck) begin
      case (ts)
         M_TLR:  ir <= 8'h01;
         M_CDR:  begin id_sr <= 32'h1234_5679; byp <= 1'b0; end
         M_SHDR: if (ir == 8'h01) id_sr <= {jtag_tdi, id_sr[31:1]}; else byp <= jtag_tdi;
         M_CIR:  ir_sr <= 8'h01;
         M_SHIR: ir_sr <= {jtag_tdi, ir_sr[7:1]};
         M_UIR:  ir <= ir_sr;
         default: ;
      endcase
      ts <= m_next(ts, jtag_tms);
   end

   always @(negedge jtag_tck)
      jtag_tdo <= ts == M_SHDR ? (ir == 8'h01 ? id_sr[0] : byp) : ts == M_SHIR ? ir_sr[0] : 1'b0;

   always @(posedge jtag_tck) begin
      tms_hist[tck_total % 1024] = jtag_tms;
      tdi_hist[tck_total % 1024] = jtag_tdi;
      tck_total++;
   end

   always @(negedge clk) begin
      if (rsp_valid) rsp_total++;
      if (cmd_ready && jtag_tck) idle_viol++;
   end

   function automatic logic [63:0] hist(input int t0, input int n, input bit tdi_sel);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = tdi_sel ? tdi_hist[(t0 + i) % 1024] : tms_hist[(t0 + i) % 1024];
      return v;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      evals++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   int last_t0;

   task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                       output int ntck, output int nrsp, output logic [63:0] rsp, output int ncyc);
      int n = 0, r0;
      while (!cmd_ready && n < 200) begin step(); n++; end
      check("send_ready", cmd_ready, 1'b1);
      last_t0 = tck_total;
      r0 = rsp_total;
      cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
      step();
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 7'($urandom); cmd_data = {$urandom, $urandom};
      ncyc = 1;
      rsp = '0;
      while (!cmd_ready && ncyc < 2000) begin
         if (rsp_valid) rsp = rsp_data;
         step();
         ncyc++;
      end
      check("send_done", ncyc < 2000, 1'b1);
      ntck = tck_total - last_t0;
      nrsp = rsp_total - r0;
   endtask

   initial begin
      int n, t0, r0, ntck, nrsp, ncyc;
      logic [63:0] rsp;
      cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tck", jtag_tck, 1'b0);
      check("rst_tms", jtag_tms, 1'b1);
      check("rst_tdi", jtag_tdi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data", rsp_data, 64'h0);
      check("rst_ready", cmd_ready, 1'b0);
      rst = 1'b0;
      t0 = tck_total;
      n = 0;
      while (!cmd_ready && n < 200) begin step(); n++; end
      check("reset_ready_cycles", n, 25);
      check("reset_tck", tck_total - t0, 6);
      check("reset_tms", hist(t0, 6, 0), 64'b011111);
      check("reset_model_rti", ts, M_RTI);

      send(OP_DR, 7'd32, 64'h0, ntck, nrsp, rsp, ncyc);
      check("dr32_tck", ntck, 37);
      check("dr32_rsp_cnt", nrsp, 1);
      check("dr32_rsp", rsp, 64'h0000_0000_1234_5679);

      send(OP_DR, 7'd0, 64'h0, ntck, nrsp, rsp, ncyc);
      check("dr_len0_tck", ntck, 6);
      check("dr_len0_rsp", rsp, 64'h1);

      send(OP_DR, 7'd70, 64'h0, ntck, nrsp, rsp, ncyc);
      check("dr_len70_tck", ntck, 69);
      check("dr_len70_rsp", rsp, 64'h0000_0000_1234_5679);

      send(OP_IR, 7'd8, 64'hA5, ntck, nrsp, rsp, ncyc);
      check("ir_tck", ntck, 14);
      check("ir_rsp_cnt", nrsp, 1);
      check("ir_rsp", rsp, 64'h01);
      check("ir_tms", hist(last_t0, 14, 0), 64'h1803);
      check("ir_tdi", hist(last_t0, 14, 1), 64'h0A50);
      check("ir_model_ir", ir, 8'hA5);
      check("ir_model_rti", ts, M_RTI);

      send(OP_DR, 7'd4, 64'hB, ntck, nrsp, rsp, ncyc);
      check("bypass_rsp", rsp, 64'h6);

      send(OP_IDLE, 7'd10, 64'h0, ntck, nrsp, rsp, ncyc);
      check("idle10_tck", ntck, 10);
      check("idle10_rsp_cnt", nrsp, 0);
      check("idle10_tms", hist(last_t0, 10, 0), 64'h0);

      send(OP_IDLE, 7'd0, 64'h0, ntck, nrsp, rsp, ncyc);
      check("idle0_tck", ntck, 0);
      check("idle0_cycles", ncyc, 2);
      check("idle0_rsp_cnt", nrsp, 0);

      // abort a SHIFT_DR during shift bit 3 (tck rise index 6)
      cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 7'd20; cmd_data = 64'hFFFFF;
      t0 = tck_total;
      r0 = rsp_total;
      step();
      cmd_valid = 1'b0;
      n = 0;
      while (tck_total - t0 < 7 && n < 500) begin step(); n++; end
      check("abort_reach", tck_total - t0, 7);
      check("abort_tck_high", jtag_tck, 1'b1);
      rst = 1'b1;
      step();
      check("abort_tck_low", jtag_tck, 1'b0);
      check("abort_busy", busy, 1'b0);
      rst = 1'b0;
      t0 = tck_total;
      n = 0;
      while (!cmd_ready && n < 200) begin step(); n++; end
      check("abort_ready_cycles", n, 25);
      check("abort_reset_tck", tck_total - t0, 6);
      check("abort_reset_tms", hist(t0, 6, 0), 64'b011111);
      check("abort_no_rsp", rsp_total - r0, 0);
      check("abort_model_ir", ir, 8'h01);

      send(OP_DR, 7'd32, 64'h0, ntck, nrsp, rsp, ncyc);
      check("after_abort_rsp", rsp, 64'h0000_0000_1234_5679);

      // back-to-back DR commands through the bypass register
      send(OP_IR, 7'd8, 64'hFF, ntck, nrsp, rsp, ncyc);
      cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 7'd8; cmd_data = 64'h3C;
      step();
      check("b2b_accept1", cmd_ready, 1'b0);
      cmd_data = 64'hC3;
      n = 0;
      while (!rsp_valid && n < 500) begin step(); n++; end
      check("b2b_rsp1", rsp_data, 64'h78);
      step();
      check("b2b_ready_after_done", cmd_ready, 1'b1);
      step();
      check("b2b_accept2", cmd_ready, 1'b0);
      cmd_valid = 1'b0; cmd_data = 64'hFF; cmd_len = 7'd3;
      n = 0;
      while (!rsp_valid && n < 500) begin step(); n++; end
      check("b2b_rsp2", rsp_data, 64'h86);
      n = 0;
      while (!cmd_ready && n < 50) begin step(); n++; end
      check("b2b_final_ready", cmd_ready, 1'b1);
      check("tck_idle_low", idle_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
      $finish;
   end
endmodule
